// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, funct, ALUOp, ALU select and control-bundle definitions
package mips_pkg;

   // Main opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   // R-type funct codes (instruction[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALUOp from the main decoder to ALU control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // ALU function select; 011 and 101 are unused and yield zero
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Control bundle carried into the EX/MEM register
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic       half;
      logic       half_unsigned;
   } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// rtl/mips_alu_core.sv - combinational ALU: add, sub, and, or, nor, signed slt
module mips_alu_core
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       select,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // Select the operation; unused codes deliberately produce zero
   always_comb begin
      result = '0;
      case (select)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_NOR: result = ~(a | b);
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_execute.sv
// rtl/mips_decode_execute.sv - main decode, ALU control and ALU with registered outputs
module mips_decode_execute
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [5:0]       op_code,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic [WIDTH-1:0] immediate,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic             half,
   output logic             half_unsigned,
   output logic [1:0]       alu_op,
   output logic [2:0]       alu_select,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero
);

   ctrl_t            ctrl_d, ctrl_q;
   logic [2:0]       sel_d, sel_q;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;

   // Main decoder: opcode to control bundle; unknown opcodes decode as a NOP
   always_comb begin
      ctrl_d = '0;
      case (op_code)
         OP_RTYPE: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_FUNCT;
         end
         OP_LW, OP_LH, OP_LHU: begin
            ctrl_d.alu_src       = 1'b1;
            ctrl_d.mem_to_reg    = 1'b1;
            ctrl_d.reg_write     = 1'b1;
            ctrl_d.mem_read      = 1'b1;
            ctrl_d.half          = (op_code != OP_LW);
            ctrl_d.half_unsigned = (op_code == OP_LHU);
         end
         OP_SW: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = ALUOP_SUB;
         end
         OP_ADDI: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
         end
         OP_ORI: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_OR;
         end
         default: ctrl_d = '0;
      endcase
   end

   // ALU control: ALUOp plus funct to ALU select; unknown funct falls back to add
   always_comb begin
      sel_d = ALU_ADD;
      case (ctrl_d.alu_op)
         ALUOP_ADD: sel_d = ALU_ADD;
         ALUOP_SUB: sel_d = ALU_SUB;
         ALUOP_OR:  sel_d = ALU_OR;
         default: begin
            case (funct)
               FN_ADD:  sel_d = ALU_ADD;
               FN_SUB:  sel_d = ALU_SUB;
               FN_AND:  sel_d = ALU_AND;
               FN_OR:   sel_d = ALU_OR;
               FN_NOR:  sel_d = ALU_NOR;
               FN_SLT:  sel_d = ALU_SLT;
               default: sel_d = ALU_ADD;
            endcase
         end
      endcase
   end

   // Operand B: ori zero-extends the low immediate half instead of using the sign extension
   always_comb begin
      operand_b = rt_data;
      if (op_code == OP_ORI)
         operand_b = {{(WIDTH-16){1'b0}}, immediate[15:0]};
      else if (ctrl_d.alu_src)
         operand_b = immediate;
   end

   mips_alu_core #(.WIDTH(WIDTH)) u_alu (
      .a      (rs_data),
      .b      (operand_b),
      .select (sel_d),
      .result (result_d),
      .zero   (zero_d)
   );

   // Output register: cleared asynchronously, loaded when the pipeline advances
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         sel_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else if (en) begin
         ctrl_q   <= ctrl_d;
         sel_q    <= sel_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign reg_dst       = ctrl_q.reg_dst;
   assign alu_src       = ctrl_q.alu_src;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign reg_write     = ctrl_q.reg_write;
   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign branch        = ctrl_q.branch;
   assign alu_op        = ctrl_q.alu_op;
   assign half          = ctrl_q.half;
   assign half_unsigned = ctrl_q.half_unsigned;
   assign alu_select    = sel_q;
   assign alu_result    = result_q;
   assign zero          = zero_q;

endmodule

// File: tb/tb_mips_decode_execute.sv
// tb/tb_mips_decode_execute.sv - self-checking bench for mips_decode_execute
module tb_mips_decode_execute;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [5:0]  op_code = '0;
   logic [5:0]  funct = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic [31:0] immediate = '0;
   logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic        half, half_unsigned, zero;
   logic [1:0]  alu_op;
   logic [2:0]  alu_select;
   logic [31:0] alu_result;
   logic [46:0] obs;
   logic [46:0] exp_v;

   int asserts = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mips_decode_execute dut (
      .clk(clk), .rst_n(rst_n), .en(en), .op_code(op_code), .funct(funct),
      .rs_data(rs_data), .rt_data(rt_data), .immediate(immediate),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .half(half), .half_unsigned(half_unsigned),
      .alu_op(alu_op), .alu_select(alu_select), .alu_result(alu_result), .zero(zero)
   );

   assign obs = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
                 alu_op, half, half_unsigned, alu_select, alu_result, zero};

   // Reference: what each instruction means, from the instruction-level rules
   function automatic logic [46:0] model(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] rs, input logic [31:0] rt,
                                         input logic [31:0] imm);
      logic [10:0] c;
      logic [2:0]  s;
      logic [31:0] r;
      logic [31:0] zimm;
      zimm = {16'h0000, imm[15:0]};
      case (op)
         6'h00: begin
            c = 11'b1001000_10_00;
            case (fn)
               6'h22: begin s = 3'b110; r = rs - rt; end
               6'h24: begin s = 3'b000; r = rs & rt; end
               6'h25: begin s = 3'b001; r = rs | rt; end
               6'h27: begin s = 3'b100; r = ~(rs | rt); end
               6'h2A: begin s = 3'b111; r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
               default: begin s = 3'b010; r = rs + rt; end
            endcase
         end
         6'h23: begin c = 11'b0111100_00_00; s = 3'b010; r = rs + imm; end
         6'h21: begin c = 11'b0111100_00_10; s = 3'b010; r = rs + imm; end
         6'h25: begin c = 11'b0111100_00_11; s = 3'b010; r = rs + imm; end
         6'h2B: begin c = 11'b0100010_00_00; s = 3'b010; r = rs + imm; end
         6'h04: begin c = 11'b0000001_01_00; s = 3'b110; r = rs - rt; end
         6'h08: begin c = 11'b0101000_00_00; s = 3'b010; r = rs + imm; end
         6'h0D: begin c = 11'b0101000_11_00; s = 3'b001; r = rs | zimm; end
         default: begin c = 11'b0; s = 3'b010; r = rs + rt; end
      endcase
      return {c, s, r, (r == 32'd0)};
   endfunction

   task automatic drive(input logic e, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
      @(negedge clk);
      en = e; op_code = op; funct = fn; rs_data = rs; rt_data = rt; immediate = imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 6'h00, 6'h20, 32'd1, 32'd2, 32'd0);
      tick();
      asserts++;
      if (obs !== 47'd0) begin
         $display("FAIL reset_state: got %h expected %h", obs, 47'd0); fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rtype_add();
      drive(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 32'd0);
      tick();
      exp_v = model(6'h00, 6'h20, 32'd5, 32'd7, 32'd0);
      asserts++;
      if (obs !== exp_v) begin
         $display("FAIL add_vector: got %h expected %h", obs, exp_v); fails++;
      end
      asserts++;
      if (alu_result !== 32'd12 || reg_dst !== 1'b1 || alu_select !== 3'b010 || zero !== 1'b0) begin
         $display("FAIL add_fields: got res=%h sel=%b expected res=0000000c sel=010", alu_result, alu_select); fails++;
      end
   endtask

   task automatic test_beq();
      drive(1'b1, 6'h04, 6'h00, 32'd9, 32'd9, 32'd0);
      tick();
      asserts++;
      if (branch !== 1'b1 || alu_select !== 3'b110 || alu_result !== 32'd0 || zero !== 1'b1 || reg_write !== 1'b0) begin
         $display("FAIL beq_equal: got br=%b sel=%b res=%h z=%b expected br=1 sel=110 res=0 z=1", branch, alu_select, alu_result, zero); fails++;
      end
      drive(1'b1, 6'h04, 6'h00, 32'd9, 32'd8, 32'd0);
      tick();
      asserts++;
      if (zero !== 1'b0 || alu_result !== 32'd1) begin
         $display("FAIL beq_unequal: got z=%b res=%h expected z=0 res=1", zero, alu_result); fails++;
      end
   endtask

   task automatic test_loads();
      drive(1'b1, 6'h23, 6'h00, 32'd100, 32'd3, 32'hFFFFFFFC);
      tick();
      exp_v = model(6'h23, 6'h00, 32'd100, 32'd3, 32'hFFFFFFFC);
      asserts++;
      if (obs !== exp_v || alu_result !== 32'd96 || mem_read !== 1'b1 || mem_to_reg !== 1'b1) begin
         $display("FAIL lw: got %h expected %h", obs, exp_v); fails++;
      end
      drive(1'b1, 6'h25, 6'h00, 32'd100, 32'd3, 32'hFFFFFFFC);
      tick();
      asserts++;
      if (half !== 1'b1 || half_unsigned !== 1'b1 || alu_result !== 32'd96 || alu_src !== 1'b1) begin
         $display("FAIL lhu: got half=%b hu=%b res=%h expected half=1 hu=1 res=60", half, half_unsigned, alu_result); fails++;
      end
   endtask

   task automatic test_slt_ori();
      drive(1'b1, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd0);
      tick();
      asserts++;
      if (alu_result !== 32'd1 || alu_select !== 3'b111) begin
         $display("FAIL slt_neg: got %h expected 00000001", alu_result); fails++;
      end
      drive(1'b1, 6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'd0);
      tick();
      asserts++;
      if (alu_result !== 32'd0 || zero !== 1'b1) begin
         $display("FAIL slt_swap: got %h expected 00000000", alu_result); fails++;
      end
      drive(1'b1, 6'h0D, 6'h00, 32'h000000F0, 32'd0, 32'hFFFF800F);
      tick();
      asserts++;
      if (alu_result !== 32'h000080FF || alu_op !== 2'b11 || alu_select !== 3'b001) begin
         $display("FAIL ori: got %h expected 000080ff", alu_result); fails++;
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 6'h00, 6'h20, 32'd3, 32'd4, 32'd0);
      tick();
      exp_v = model(6'h00, 6'h20, 32'd3, 32'd4, 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 6'h2B, 6'h22, $urandom, $urandom, $urandom);
         tick();
         asserts++;
         if (obs !== exp_v) begin
            $display("FAIL hold_%0d: got %h expected %h", i, obs, exp_v); fails++;
         end
      end
   endtask

   task automatic test_unknown_op();
      drive(1'b1, 6'h3F, 6'h24, 32'd10, 32'd20, 32'hFFFFFFFF);
      tick();
      asserts++;
      if (obs[46:36] !== 11'd0 || alu_result !== 32'd30) begin
         $display("FAIL unknown_op: got ctrl=%b res=%h expected ctrl=0 res=1e", obs[46:36], alu_result); fails++;
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 6'h00, 6'h25, 32'hA5, 32'h5A, 32'd0);
      tick();
      exp_v = model(6'h00, 6'h25, 32'hA5, 32'h5A, 32'd0);
      asserts++;
      if (obs !== exp_v) begin
         $display("FAIL pre_reset: got %h expected %h", obs, exp_v); fails++;
      end
      #2 rst_n = 1'b0;
      #1;
      asserts++;
      if (obs !== 47'd0) begin
         $display("FAIL async_reset: got %h expected 0", obs); fails++;
      end
      tick();
      asserts++;
      if (obs !== 47'd0) begin
         $display("FAIL reset_hold: got %h expected 0", obs); fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 6'h00, 6'h22, 32'd50, 32'd8, 32'd0);
      tick();
      exp_v = model(6'h00, 6'h22, 32'd50, 32'd8, 32'd0);
      asserts++;
      if (obs !== exp_v || alu_result !== 32'd42) begin
         $display("FAIL post_reset: got %h expected %h", obs, exp_v); fails++;
      end
   endtask

   task automatic test_random();
      logic [5:0]  ops [9];
      logic [5:0]  fns [7];
      logic [5:0]  op, fn;
      logic [31:0] rs, rt, imm;
      logic        e;
      logic [46:0] prev;
      ops = '{6'h00, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
      prev = obs;
      for (int i = 0; i < 300; i++) begin
         op  = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
         fn  = ($urandom_range(0, 7) == 7) ? 6'($urandom) : fns[$urandom_range(0, 6)];
         rs  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         rt  = ($urandom_range(0, 5) == 0) ? rs : 32'($urandom);
         imm = {{16{1'b0}}, 16'($urandom)};
         imm = {{16{imm[15]}}, imm[15:0]};
         e   = ($urandom_range(0, 4) != 0);
         drive(e, op, fn, rs, rt, imm);
         tick();
         exp_v = e ? model(op, fn, rs, rt, imm) : prev;
         asserts++;
         if (obs !== exp_v) begin
            $display("FAIL random_%0d op=%h fn=%h en=%b: got %h expected %h", i, op, fn, e, obs, exp_v); fails++;
         end
         prev = exp_v;
      end
   endtask

   initial begin
      test_reset();
      test_rtype_add();
      test_beq();
      test_loads();
      test_slt_ori();
      test_hold();
      test_unknown_op();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/mips_decode_execute.md
Name: mips_decode_execute

Overview:
Combined main-decoder, ALU-control and 32-bit ALU for the 5-stage MIPS pipeline, covering the ID-to-EX portion of the datapath. It takes the opcode, funct, operands and sign-extended immediate, and generates pipeline control signals and the ALU result. All outputs are registered once, so they can feed the EX/MEM pipeline register directly.

Parameters:
WIDTH, 32, datapath width. Operands, immediate and result are all WIDTH bits.

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  pipeline advance (the top level's ready); 0 = hold all outputs
op_code  input  6  instruction[31:26]
funct  input  6  instruction[5:0]
rs_data  input  32  register-file read data 1 (ALU operand A)
rt_data  input  32  register-file read data 2
immediate  input  32  sign-extended instruction[15:0]
reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  output  1 each  registered control signals
half, half_unsigned  output  1 each  registered halfword-load flags
alu_op  output  2  registered ALUOp
alu_select  output  3  registered ALU function code
alu_result  output  32  registered ALU result
zero  output  1  registered (alu_result == 0)

Behaviour:
- rst_n=0: every output goes to 0 immediately (asynchronous) and stays 0 while rst_n is low. Reset has priority over en.
- Rising edge with en=1: all outputs capture the combinational decode and ALU result of the current inputs. Latency is 1 cycle.
- Rising edge with en=0: all outputs hold their values.
- Main decode of op_code, giving {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, half, half_unsigned}:
  - 0x00 R-type: 1,0,0,1,0,0,0,10,0,0
  - 0x23 lw: 0,1,1,1,1,0,0,00,0,0
  - 0x21 lh: as lw, with half=1
  - 0x25 lhu: as lw, with half=1 and half_unsigned=1
  - 0x2B sw: 0,1,0,0,0,1,0,00,0,0
  - 0x04 beq: 0,0,0,0,0,0,1,01,0,0
  - 0x08 addi: 0,1,0,1,0,0,0,00,0,0
  - 0x0D ori: 0,1,0,1,0,0,0,11,0,0
  - Any other opcode: all controls 0 (NOP); alu_op=00.
- mem_to_reg=1 means write-back selects memory data.
- ALU control (alu_op, funct) -> alu_select:
  - alu_op 00 -> 010 ADD
  - alu_op 01 -> 110 SUB
  - alu_op 11 -> 001 OR
  - alu_op 10 decodes funct: 0x20 -> 010 ADD; 0x22 -> 110 SUB; 0x24 -> 000 AND; 0x25 -> 001 OR; 0x27 -> 100 NOR; 0x2A -> 111 SLT; any other funct -> 010 ADD.
- ALU operands:
  - A = rs_data.
  - B = rt_data when alu_src=0.
  - B = immediate when alu_src=1, except ori, which uses {16'b0, immediate[15:0]}.
- ALU operations:
  - ADD/SUB: two's complement, wraps modulo 2^32; no overflow flag or trap.
  - AND, OR, NOR: bitwise.
  - SLT: signed compare, result 32'd1 or 32'd0.
  - Unused select codes (011, 101): result 0.
- zero: computed from the same-cycle ALU result and registered alongside it.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ, OP_ADDI, OP_ORI)
  - funct constants
  - ALUOp encodings
  - alu_select encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SUB, ALU_SLT)
  - packed control-bundle typedef
- Natural sub-module: mips_alu_core, a purely combinational ALU (a, b, select -> result, zero).
- Decode and ALU-control logic stays inline in mips_decode_execute.

Test Plan:
- R-type add: op 0x00, funct 0x20, rs=5, rt=7, en=1 -> after 1 edge: alu_result=12, zero=0, reg_dst=1, reg_write=1, alu_select=010.
- beq: op 0x04, rs=rt=9 -> branch=1, alu_select=110, alu_result=0, zero=1, reg_write=0. Repeat with rt=8 -> zero=0.
- lw: op 0x23, rs=100, imm=0xFFFFFFFC -> alu_result=96, alu_src=1, mem_read=1, mem_to_reg=1. lhu (op 0x25) additionally gives half=1, half_unsigned=1.
- slt and ori:
  - slt: funct 0x2A, rs=0xFFFFFFFF, rt=1 -> alu_result=1. Swap operands -> 0.
  - ori: op 0x0D, rs=0xF0, imm=0xFFFF800F -> alu_result=0x0000_80FF.
- Hold: load an add result, then set en=0 and change inputs -> outputs unchanged for 3 edges. Unknown opcode 0x3F with en=1 -> all controls 0.
- Reset mid-operation: outputs non-zero, rst_n low between edges -> all outputs 0 before the next edge. Release rst_n -> first enabled edge loads normally.
